// File: rtl/core_pkg.sv
// Shared definitions for the core load/store unit.
//   - One-hot LSU state encodings (same style as the cpu_state encodings)
//   - Byte-strobe base patterns for byte / half / word stores
//   - Reset value for data-carrying registers
//   - Decoded load/store operation bundle and small classification helpers
package core_pkg;

    // One-hot LSU states
    localparam logic [2:0] LSU_IDLE   = 3'b001;
    localparam logic [2:0] LSU_ACCESS = 3'b010;
    localparam logic [2:0] LSU_RESP   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = LSU_IDLE,
        ST_ACCESS = LSU_ACCESS,
        ST_RESP   = LSU_RESP
    } lsu_state_t;

    // Byte-strobe base patterns, shifted left by the byte offset for stores
    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    localparam logic [31:0] RESET_VAL = 32'b0;

    // Decoded operation flags, expected one-hot
    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
    } lsu_op_t;

    function automatic logic op_is_store(input lsu_op_t op);
        return op.sb | op.sh | op.sw;
    endfunction

    function automatic logic op_is_load(input lsu_op_t op);
        return op.lb | op.lh | op.lw | op.lbu | op.lhu;
    endfunction

endpackage

// File: rtl/core_lsu_if.sv
// Data-memory port between the load/store unit and data memory.
// Single-outstanding request/ready protocol:
//   D_MEM_REQ    request valid (master -> slave)
//   D_MEM_ADDR   word-aligned byte address
//   D_MEM_WE     1 = store
//   D_MEM_WSTRB  byte enables (0 for loads)
//   D_MEM_WDATA  lane-replicated store data
//   D_MEM_READY  memory accepts / returns data this cycle (slave -> master)
//   D_MEM_RDATA  read word, valid when READY and WE=0
interface core_lsu_if;
    logic        D_MEM_REQ;
    logic [31:0] D_MEM_ADDR;
    logic        D_MEM_WE;
    logic [3:0]  D_MEM_WSTRB;
    logic [31:0] D_MEM_WDATA;
    logic        D_MEM_READY;
    logic [31:0] D_MEM_RDATA;

    modport master (
        output D_MEM_REQ, D_MEM_ADDR, D_MEM_WE, D_MEM_WSTRB, D_MEM_WDATA,
        input  D_MEM_READY, D_MEM_RDATA
    );

    modport slave (
        input  D_MEM_REQ, D_MEM_ADDR, D_MEM_WE, D_MEM_WSTRB, D_MEM_WDATA,
        output D_MEM_READY, D_MEM_RDATA
    );
endinterface

// File: rtl/core_lsu_align.sv
// Combinational lane logic for the load/store unit.
// Inputs:  op (decoded flags), off (byte offset ADDR[1:0]), wdata (store
//          data from rs2), rdata (word read from memory)
// Outputs: wstrb (byte enables, 0 for loads), wdata_rep (lane-replicated
//          store data), load_val (extracted + extended load result),
//          misalign (access crosses its natural alignment)
module core_lsu_align
    import core_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        // Bring the addressed byte/half down to bit 0
        shifted   = rdata >> {off, 3'b000};

        wstrb     = 4'b0000;
        wdata_rep = wdata;
        if (op.sb) begin
            wstrb     = WSTRB_BYTE << off;
            wdata_rep = {4{wdata[7:0]}};
        end else if (op.sh) begin
            wstrb     = WSTRB_HALF << off;
            wdata_rep = {2{wdata[15:0]}};
        end else if (op.sw) begin
            wstrb     = WSTRB_WORD;
        end

        load_val = RESET_VAL;
        if (op.lb)
            load_val = {{24{shifted[7]}}, shifted[7:0]};
        else if (op.lbu)
            load_val = {24'b0, shifted[7:0]};
        else if (op.lh)
            load_val = {{16{shifted[15]}}, shifted[15:0]};
        else if (op.lhu)
            load_val = {16'b0, shifted[15:0]};
        else if (op.lw)
            load_val = shifted;

        misalign = ((op.lh | op.lhu | op.sh) & off[0]) |
                   ((op.lw | op.sw) & (off != 2'b00));
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit for the memory-access stage.
// Accepts one decoded load/store per START, runs a single-outstanding
// request/ready access on the data-memory port, and returns the extended
// load result with a one-cycle DONE pulse.
// Ports:
//   CLK, RST        clock, synchronous active-low reset
//   START           one-cycle request (ignored while BUSY)
//   I_L*/I_S*       one-hot decoded load/store flags
//   ADDR, WDATA     effective byte address, store data
//   BUSY            state != IDLE
//   DONE            one-cycle completion pulse
//   RDATA           extended load result, held until next accepted START
//   MISALIGN        with DONE: misaligned access, no bus cycle issued
//   BUS_ERR         with DONE: memory did not respond within TIMEOUT cycles
//   dmem            data-memory port (master side)
module core_lsu
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        MISALIGN,
    output logic        BUS_ERR,
    core_lsu_if.master  dmem
);

    lsu_state_t       state;
    lsu_op_t          op_in;
    lsu_op_t          op_q;
    lsu_op_t          sel_op;
    logic [7:0]       op_in_bits;
    logic [1:0]       off_q;
    logic [1:0]       sel_off;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      wdata_q;

    logic [3:0]       al_wstrb;
    logic [31:0]      al_wdata;
    logic [31:0]      al_load;
    logic             al_misalign;

    assign op_in      = {I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW};
    assign op_in_bits = op_in;

    // In IDLE the lane logic looks at the incoming request (misalign check,
    // store lanes); afterwards it looks at the latched op/offset so the load
    // extract matches the access in flight.
    assign sel_op  = (state == ST_IDLE) ? op_in      : op_q;
    assign sel_off = (state == ST_IDLE) ? ADDR[1:0]  : off_q;

    core_lsu_align u_align (
        .op        (sel_op),
        .off       (sel_off),
        .wdata     (WDATA),
        .rdata     (dmem.D_MEM_RDATA),
        .wstrb     (al_wstrb),
        .wdata_rep (al_wdata),
        .load_val  (al_load),
        .misalign  (al_misalign)
    );

    // TIMEOUT=0 disables the abort entirely
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            off_q    <= 2'b00;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= RESET_VAL;
            wstrb_q  <= 4'b0000;
            wdata_q  <= RESET_VAL;
            DONE     <= 1'b0;
            RDATA    <= RESET_VAL;
            MISALIGN <= 1'b0;
            BUS_ERR  <= 1'b0;
        end else begin
            // Status flags are only ever high for the single RESP cycle
            DONE     <= 1'b0;
            MISALIGN <= 1'b0;
            BUS_ERR  <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        op_q  <= op_in;
                        off_q <= ADDR[1:0];
                        cnt_q <= '0;
                        if (!$onehot(op_in_bits)) begin
                            // Malformed decode: complete as a no-op
                            state <= ST_RESP;
                            DONE  <= 1'b1;
                            RDATA <= RESET_VAL;
                        end else if (al_misalign) begin
                            state    <= ST_RESP;
                            DONE     <= 1'b1;
                            MISALIGN <= 1'b1;
                        end else begin
                            state   <= ST_ACCESS;
                            req_q   <= 1'b1;
                            addr_q  <= {ADDR[31:2], 2'b00};
                            we_q    <= op_is_store(op_in);
                            wstrb_q <= al_wstrb;
                            wdata_q <= al_wdata;
                        end
                    end
                end

                ST_ACCESS: begin
                    // READY takes priority over a timeout in the same cycle
                    if (dmem.D_MEM_READY) begin
                        req_q <= 1'b0;
                        state <= ST_RESP;
                        DONE  <= 1'b1;
                        if (op_is_load(op_q))
                            RDATA <= al_load;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        state   <= ST_RESP;
                        DONE    <= 1'b1;
                        BUS_ERR <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY             = (state != ST_IDLE);
    assign dmem.D_MEM_REQ   = req_q;
    assign dmem.D_MEM_ADDR  = addr_q;
    assign dmem.D_MEM_WE    = we_q;
    assign dmem.D_MEM_WSTRB = wstrb_q;
    assign dmem.D_MEM_WDATA = wdata_q;

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
Load/store unit filling the memory-access stage between the ALU (execute) and register writeback. It accepts one decoded load/store per START pulse, with address and store data. It drives a single-outstanding request/ready data-memory port with word address, byte strobes and lane-replicated store data. It returns the sign- or zero-extended load result to writeback with a one-cycle DONE pulse, and flags misalignment or bus timeout.

Parameters:
TIMEOUT, 255, cycles to wait for D_MEM_READY before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
CLK  in  1  core clock, all logic on rising edge
RST  in  1  reset, synchronous, active-low
START  in  1  one-cycle request from core FSM entering MEMORY
I_LB, I_LH, I_LW, I_LBU, I_LHU  in  1 each  decoded load flags, one-hot
I_SB, I_SH, I_SW  in  1 each  decoded store flags, one-hot
ADDR  in  32  effective byte address (ALU result)
WDATA  in  32  store data (rs2)
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle completion pulse
RDATA  out  32  extended load result; held until next accepted START
MISALIGN  out  1  valid with DONE; misaligned access, no bus cycle
BUS_ERR  out  1  valid with DONE; timeout abort
D_MEM_REQ  out  1  request valid
D_MEM_ADDR  out  32  {ADDR[31:2],2'b00}
D_MEM_WE  out  1  1 = store
D_MEM_WSTRB  out  4  byte enables, 0 for loads
D_MEM_WDATA  out  32  lane-replicated store data
D_MEM_READY  in  1  memory accepts / returns data this cycle
D_MEM_RDATA  in  32  read word, valid when READY and WE=0

Behaviour:
- Reset (RST=0 at an edge): state IDLE; every output 0 including RDATA; counter 0.
- Reset mid-transaction aborts it: REQ drops at that edge and no DONE is produced.
- One-hot states: IDLE, ACCESS, RESP.
- IDLE, START=1:
  - Latch op, ADDR and WDATA.
  - Zero flags or more than one flag set: go to RESP as a no-op, RDATA=0, no errors.
  - Misaligned: go to RESP with MISALIGN=1, no bus cycle, RDATA unchanged.
  - Otherwise: go to ACCESS.
- START while BUSY is ignored.
- Misalignment rule:
  - LH, LHU, SH: ADDR[0]=1.
  - LW, SW: ADDR[1:0] != 0.
  - LB, LBU, SB: never misaligned.
- ACCESS:
  - D_MEM_REQ=1.
  - ADDR, WE, WSTRB and WDATA stay stable until READY is sampled high.
  - READY=1: go to RESP next edge; loads capture the extracted word into RDATA.
  - READY=0: counter increments.
  - Counter == TIMEOUT-1 with READY=0: drop REQ, go to RESP with BUS_ERR=1. READY in that same cycle wins.
  - Counter clears on entry to ACCESS.
- RESP: DONE=1 for exactly one cycle, then IDLE. MISALIGN and BUS_ERR are 0 outside RESP.
- Store lanes, with off=ADDR[1:0]:
  - SB: WSTRB = 4'b0001<<off, WDATA = {4{WDATA[7:0]}}.
  - SH: WSTRB = 4'b0011<<off, WDATA = {2{WDATA[15:0]}}.
  - SW: WSTRB = 4'b1111, WDATA = WDATA.
- Load extract: byte = D_MEM_RDATA >> (off*8).
  - LB: sign-extend bit 7. LBU: zero-extend.
  - LH: sign-extend bit 15. LHU: zero-extend.
  - LW: full word.
- Latency:
  - Zero-wait access: START at cycle N, REQ at N+1, DONE at N+2.
  - Each wait cycle adds 1.
  - Misaligned or no-op: DONE at N+1.
- A new START is accepted in the cycle after DONE (back-to-back allowed).

Decomposition:
- Shared package core_pkg holds:
  - one-hot LSU state localparams, matching the cpu_state style
  - WSTRB constants: byte 4'b0001, half 4'b0011, word 4'b1111
  - RESET_VAL 32'b0
- Sub-module core_lsu_align: purely combinational.
  - Inputs: op flags, off, WDATA, D_MEM_RDATA.
  - Outputs: WSTRB, replicated WDATA, extended load value, misalign flag.
- core_lsu keeps the FSM, latches and counter.

Test Plan:
- LB from ADDR=0x0000_1003, memory returns 0x80AA_BBCC with READY on first REQ cycle -> D_MEM_ADDR=0x0000_1000, WSTRB=0, RDATA=0xFFFF_FF80, DONE exactly 2 cycles after START.
- LHU from ADDR=0x2002, RDATA word 0x8001_1234, READY after 3 wait cycles -> RDATA=0x0000_8001, DONE at START+5, REQ/ADDR stable throughout.
- SB at ADDR=0x10 with WDATA=0x1234_56A5, then SH at 0x12 with WDATA=0x0000_BEEF -> WSTRB=0001, WDATA=0xA5A5_A5A5; then WSTRB=1100, WDATA=0xBEEF_BEEF, WE=1.
- SW at ADDR=0x0000_0006 -> no REQ ever, DONE and MISALIGN at START+1, RDATA unchanged.
- TIMEOUT=4, LW with READY held 0 -> REQ for 4 cycles then low, DONE+BUS_ERR next cycle; second case with READY arriving on 4th cycle -> normal completion, BUS_ERR=0.
- RST driven low while in ACCESS waiting -> REQ=0 at next edge, no DONE; START after RST=1 with LW at 0x40 completes normally.
